// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and elaboration helpers for the parametrised dual-port RAM
package ram_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } clr_state_t;

   function automatic int lanes(input int width);
      return width / BYTE_W;
   endfunction

   function automatic bit read_lat_legal(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

endpackage

// File: rtl/ram_syn_dual_param_if.sv
// rtl/ram_syn_dual_param_if.sv - write/read/clear port bundle of the dual-port RAM
interface ram_syn_dual_param_if
   import ram_pkg::*;
#(
   parameter int RAM_WIDTH = 128,
   parameter int RAM_ADDR  = 12
);
   localparam int LANES = lanes(RAM_WIDTH);

   logic                 chip_select;
   logic                 write_en;
   logic [RAM_ADDR-1:0]  wr_addr;
   logic [RAM_WIDTH-1:0] data_in;
   logic [LANES-1:0]     byte_en;
   logic                 read_en;
   logic [RAM_ADDR-1:0]  rd_addr;
   logic                 clear_req;
   logic [RAM_WIDTH-1:0] data_out;
   logic                 rd_valid;
   logic                 init_busy;

   modport master (
      output chip_select, write_en, wr_addr, data_in, byte_en,
             read_en, rd_addr, clear_req,
      input  data_out, rd_valid, init_busy
   );

   modport slave (
      input  chip_select, write_en, wr_addr, data_in, byte_en,
             read_en, rd_addr, clear_req,
      output data_out, rd_valid, init_busy
   );

endinterface

// File: rtl/ram_clear_fsm.sv
// rtl/ram_clear_fsm.sv - post-reset / on-request sweep that writes the clear value to every word
module ram_clear_fsm
   import ram_pkg::*;
#(
   parameter int RAM_ADDR  = 12,
   parameter int RAM_DEPTH = 4096
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear_req,
   output logic                init_busy,
   output logic                clr_we,
   output logic [RAM_ADDR-1:0] clr_addr
);

   localparam logic [RAM_ADDR-1:0] LAST = RAM_ADDR'(RAM_DEPTH - 1);

   clr_state_t          state, state_nxt;
   logic [RAM_ADDR-1:0] ptr, ptr_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // clear_req is only honoured from IDLE; a request mid-sweep is dropped
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      init_busy = 1'b0;
      clr_we    = 1'b0;
      case (state)
         ST_CLEAR: begin
            init_busy = 1'b1;
            clr_we    = 1'b1;
            if (ptr == LAST) begin
               state_nxt = ST_IDLE;
               ptr_nxt   = '0;
            end else begin
               ptr_nxt = ptr + RAM_ADDR'(1);
            end
         end
         ST_IDLE: begin
            if (clear_req) begin
               state_nxt = ST_CLEAR;
               ptr_nxt   = '0;
            end
         end
         default: state_nxt = ST_CLEAR;
      endcase
   end

   assign clr_addr = ptr;

endmodule

// File: rtl/ram_syn_dual_param.sv
// rtl/ram_syn_dual_param.sv - 1W/1R synchronous RAM with byte lanes, write-first forwarding and 1/2-cycle read
module ram_syn_dual_param
   import ram_pkg::*;
#(
   parameter int                   RAM_WIDTH = 128,
   parameter int                   RAM_ADDR  = 12,
   parameter int                   RAM_DEPTH = 4096,
   parameter int                   READ_LAT  = 1,
   parameter logic [RAM_WIDTH-1:0] CLEAR_VAL = '0
) (
   input logic                 clock,
   input logic                 reset,
   ram_syn_dual_param_if.slave bus
);

   localparam int                  LANES   = lanes(RAM_WIDTH);
   localparam logic [RAM_ADDR:0]   DEPTH_W = (RAM_ADDR + 1)'(RAM_DEPTH);

   if (!read_lat_legal(READ_LAT)) begin : g_bad_lat
      $error("ram_syn_dual_param: READ_LAT must be 1 or 2");
   end
   if ((RAM_WIDTH % BYTE_W) != 0 || RAM_DEPTH > (2 ** RAM_ADDR)) begin : g_bad_geom
      $error("ram_syn_dual_param: illegal RAM_WIDTH/RAM_DEPTH/RAM_ADDR combination");
   end

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

   logic                 init_busy;
   logic                 clr_we;
   logic [RAM_ADDR-1:0]  clr_addr;
   logic                 wr_acc;
   logic                 rd_acc;
   logic [RAM_WIDTH-1:0] rd_word;
   logic [RAM_WIDTH-1:0] s1_data;
   logic                 s1_valid;

   ram_clear_fsm #(
      .RAM_ADDR  (RAM_ADDR),
      .RAM_DEPTH (RAM_DEPTH)
   ) u_clear (
      .clock     (clock),
      .reset     (reset),
      .clear_req (bus.clear_req),
      .init_busy (init_busy),
      .clr_we    (clr_we),
      .clr_addr  (clr_addr)
   );

   assign bus.init_busy = init_busy;

   assign wr_acc = bus.chip_select & bus.write_en & ~init_busy & ({1'b0, bus.wr_addr} < DEPTH_W);
   assign rd_acc = bus.chip_select & bus.read_en & ~init_busy;

   // Array itself is never reset; the sweep owns the port while busy
   always_ff @(posedge clock) begin
      if (clr_we) begin
         mem[clr_addr] <= CLEAR_VAL;
      end else if (wr_acc) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.byte_en[i]) begin
               mem[bus.wr_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
            end
         end
      end
   end

   // Same-address write in the same cycle is merged lane-by-lane (write-first)
   always_comb begin
      rd_word = '0;
      if ({1'b0, bus.rd_addr} < DEPTH_W) begin
         rd_word = mem[bus.rd_addr];
      end
      if (wr_acc && (bus.wr_addr == bus.rd_addr)) begin
         for (int i = 0; i < LANES; i++) begin
            if (bus.byte_en[i]) begin
               rd_word[8*i +: 8] = bus.data_in[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_data  <= '0;
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= rd_acc;
         if (rd_acc) begin
            s1_data <= rd_word;
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic [RAM_WIDTH-1:0] s2_data;
      logic                 s2_valid;

      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            s2_data  <= '0;
            s2_valid <= 1'b0;
         end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_data;
            end
         end
      end

      assign bus.data_out = s2_data;
      assign bus.rd_valid = s2_valid;
   end else begin : g_lat1
      assign bus.data_out = s1_data;
      assign bus.rd_valid = s1_valid;
   end

endmodule

// File: tb/tb_ram_syn_dual_param.sv
// tb/tb_ram_syn_dual_param.sv - directed bench: 4096x128 READ_LAT=1 instance and 20x32 READ_LAT=2 instance
module tb_ram_syn_dual_param;

   logic clock = 1'b0;
   logic rst_a;
   logic rst_b;

   always #5 clock = ~clock;

   ram_syn_dual_param_if #(.RAM_WIDTH(128), .RAM_ADDR(12)) bus_a ();
   ram_syn_dual_param_if #(.RAM_WIDTH(32),  .RAM_ADDR(5))  bus_b ();

   ram_syn_dual_param #(
      .RAM_WIDTH (128),
      .RAM_ADDR  (12),
      .RAM_DEPTH (4096),
      .READ_LAT  (1),
      .CLEAR_VAL ('0)
   ) dut_a (
      .clock (clock),
      .reset (rst_a),
      .bus   (bus_a)
   );

   ram_syn_dual_param #(
      .RAM_WIDTH (32),
      .RAM_ADDR  (5),
      .RAM_DEPTH (20),
      .READ_LAT  (2),
      .CLEAR_VAL (32'hC0DE_0A11)
   ) dut_b (
      .clock (clock),
      .reset (rst_b),
      .bus   (bus_b)
   );

   localparam logic [127:0] ALL_A5   = {16{8'hA5}};
   localparam logic [127:0] ALL_3C   = {16{8'h3C}};
   localparam logic [127:0] ALL_5A   = {16{8'h5A}};
   localparam logic [127:0] ALL_FF   = {16{8'hFF}};
   localparam logic [127:0] MERGE_F0 = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000;
   localparam logic [31:0]  CLR_B    = 32'hC0DE_0A11;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Inputs applied at a falling edge; on return the following falling edge has been reached
   task automatic cyc_a(input logic cs, input logic we, input logic [11:0] wa,
                        input logic [127:0] d, input logic [15:0] be,
                        input logic re, input logic [11:0] ra, input logic clr);
      bus_a.chip_select = cs;
      bus_a.write_en    = we;
      bus_a.wr_addr     = wa;
      bus_a.data_in     = d;
      bus_a.byte_en     = be;
      bus_a.read_en     = re;
      bus_a.rd_addr     = ra;
      bus_a.clear_req   = clr;
      @(negedge clock);
   endtask

   task automatic cyc_b(input logic cs, input logic we, input logic [4:0] wa,
                        input logic [31:0] d, input logic [3:0] be,
                        input logic re, input logic [4:0] ra, input logic clr);
      bus_b.chip_select = cs;
      bus_b.write_en    = we;
      bus_b.wr_addr     = wa;
      bus_b.data_in     = d;
      bus_b.byte_en     = be;
      bus_b.read_en     = re;
      bus_b.rd_addr     = ra;
      bus_b.clear_req   = clr;
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus_a.chip_select = 0; bus_a.write_en = 0; bus_a.wr_addr = '0; bus_a.data_in = '0;
      bus_a.byte_en = '0; bus_a.read_en = 0; bus_a.rd_addr = '0; bus_a.clear_req = 0;
      bus_b.chip_select = 0; bus_b.write_en = 0; bus_b.wr_addr = '0; bus_b.data_in = '0;
      bus_b.byte_en = '0; bus_b.read_en = 0; bus_b.rd_addr = '0; bus_b.clear_req = 0;
   endtask

   initial begin
      logic [31:0] exp_b [4];
      int n;
      int bad;

      exp_b = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      rst_a = 1'b1;
      rst_b = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clock);

      check_eq("rst_data_out_a", bus_a.data_out, '0);
      check_eq("rst_rd_valid_a", bus_a.rd_valid, 0);
      check_eq("rst_init_busy_a", bus_a.init_busy, 1);
      check_eq("rst_init_busy_b", bus_b.init_busy, 1);

      rst_a = 1'b0;
      n = 0;
      while (bus_a.init_busy && n < 5000) begin
         n++;
         @(negedge clock);
      end
      check_eq("sweep_len_a", n, 4096);

      cyc_a(1, 0, 0, '0, '0, 1, 12'd0, 0);
      check_eq("rd0_valid", bus_a.rd_valid, 1);
      check_eq("rd0_data", bus_a.data_out, '0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd4095, 0);
      check_eq("rd4095_valid", bus_a.rd_valid, 1);
      check_eq("rd4095_data", bus_a.data_out, '0);
      cyc_a(0, 0, 0, '0, '0, 0, 0, 0);
      check_eq("no_read_valid", bus_a.rd_valid, 0);

      cyc_a(1, 1, 12'd2, ALL_A5, 16'hFFFF, 0, 0, 0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd2, 0);
      check_eq("wr2_rd_data", bus_a.data_out, ALL_A5);

      cyc_a(1, 1, 12'd2, '0, 16'h0000, 0, 0, 0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd2, 0);
      check_eq("be0_noop", bus_a.data_out, ALL_A5);

      cyc_a(1, 1, 12'd3, ALL_3C, 16'hFFFF, 1, 12'd2, 0);
      check_eq("rdw_diff_addr", bus_a.data_out, ALL_A5);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd3, 0);
      check_eq("rd3_after_rdw", bus_a.data_out, ALL_3C);

      cyc_a(1, 1, 12'd7, '0, 16'hFFFF, 0, 0, 0);
      cyc_a(1, 1, 12'd7, ALL_FF, 16'h00F0, 1, 12'd7, 0);
      check_eq("rdw_merge_valid", bus_a.rd_valid, 1);
      check_eq("rdw_merge_data", bus_a.data_out, MERGE_F0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd7, 0);
      check_eq("rd7_after_merge", bus_a.data_out, MERGE_F0);

      cyc_a(0, 1, 12'd9, ALL_FF, 16'hFFFF, 1, 12'd9, 0);
      check_eq("cs0_valid", bus_a.rd_valid, 0);
      check_eq("cs0_hold", bus_a.data_out, MERGE_F0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd9, 0);
      check_eq("cs0_no_write", bus_a.data_out, '0);

      cyc_a(1, 1, 12'd5, ALL_5A, 16'hFFFF, 0, 0, 0);
      cyc_a(1, 1, 12'd6, ALL_3C, 16'hFFFF, 1, 12'd5, 1);
      check_eq("clrreq_cycle_served", bus_a.data_out, ALL_5A);
      check_eq("clrreq_busy", bus_a.init_busy, 1);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd5, 0);
      check_eq("busy_read_blocked", bus_a.rd_valid, 0);
      idle_inputs();
      repeat (98) @(negedge clock);
      rst_a = 1'b1;
      @(negedge clock);
      check_eq("midsweep_rst_busy", bus_a.init_busy, 1);
      check_eq("midsweep_rst_data", bus_a.data_out, '0);
      rst_a = 1'b0;
      n = 0;
      while (bus_a.init_busy && n < 5000) begin
         if (n == 200) begin
            bus_a.chip_select = 1; bus_a.write_en = 1; bus_a.wr_addr = 12'd10;
            bus_a.data_in = ALL_FF; bus_a.byte_en = 16'hFFFF;
         end else begin
            idle_inputs();
         end
         n++;
         @(negedge clock);
      end
      idle_inputs();
      check_eq("sweep_len_restart", n, 4096);

      cyc_a(1, 0, 0, '0, '0, 1, 12'd10, 0);
      check_eq("busy_write_dropped", bus_a.data_out, '0);
      cyc_a(1, 0, 0, '0, '0, 1, 12'd6, 0);
      check_eq("cleared_addr6", bus_a.data_out, '0);
      bad = 0;
      for (int a = 0; a < 4096; a++) begin
         cyc_a(1, 0, 0, '0, '0, 1, 12'(a), 0);
         if (bus_a.rd_valid !== 1'b1 || bus_a.data_out !== '0) bad++;
      end
      check_eq("all_words_cleared", bad, 0);
      idle_inputs();

      rst_b = 1'b0;
      n = 0;
      while (bus_b.init_busy && n < 200) begin
         n++;
         @(negedge clock);
      end
      check_eq("sweep_len_b", n, 20);

      cyc_b(1, 0, 0, '0, '0, 1, 5'd19, 0);
      check_eq("lat2_first_edge", bus_b.rd_valid, 0);
      cyc_b(0, 0, 0, '0, '0, 0, 0, 0);
      check_eq("lat2_rd19_valid", bus_b.rd_valid, 1);
      check_eq("lat2_rd19_clrval", bus_b.data_out, CLR_B);

      for (int i = 0; i < 4; i++) cyc_b(1, 1, 5'(i), exp_b[i], 4'hF, 0, 0, 0);
      for (int c = 0; c < 6; c++) begin
         if (c < 4) cyc_b(1, 0, 0, '0, '0, 1, 5'(c), 0);
         else       cyc_b(0, 0, 0, '0, '0, 0, 0, 0);
         if (c >= 1 && c <= 4) begin
            check_eq($sformatf("b2b_valid_%0d", c), bus_b.rd_valid, 1);
            check_eq($sformatf("b2b_data_%0d", c), bus_b.data_out, exp_b[c-1]);
         end else begin
            check_eq($sformatf("b2b_gap_%0d", c), bus_b.rd_valid, 0);
         end
      end
      check_eq("lat2_hold", bus_b.data_out, exp_b[3]);

      cyc_b(1, 1, 5'd25, 32'hFFFF_FFFF, 4'hF, 1, 5'd25, 0);
      cyc_b(0, 0, 0, '0, '0, 0, 0, 0);
      check_eq("oob_rd_valid", bus_b.rd_valid, 1);
      check_eq("oob_rd_zero", bus_b.data_out, '0);

      cyc_b(0, 0, 0, '0, '0, 0, 0, 1);
      n = 0;
      while (bus_b.init_busy && n < 200) begin
         bus_b.clear_req = (n == 5);
         n++;
         @(negedge clock);
      end
      bus_b.clear_req = 0;
      check_eq("clrreq_ignored_in_sweep", n, 20);
      cyc_b(1, 0, 0, '0, '0, 1, 5'd0, 0);
      cyc_b(0, 0, 0, '0, '0, 0, 0, 0);
      check_eq("b_recleared_addr0", bus_b.data_out, CLR_B);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
